// File: rtl/offset_field_encoder.sv
// rtl/offset_field_encoder.sv - multi-cycle branch/jump target to signed offset field encoder
//
// Computes target - pc, scales it down by SHIFT for jumps, checks alignment
// and range, and returns the packed immediate field together with error flags.
// Sequence: IDLE -> SUB -> ALIGN -> RANGE -> DONE -> IDLE, one cycle per state
// except DONE, which waits for out_ready.
//
// Optional feature macro: OFFSET_FIELD_ENCODER_SATURATE_EN
//   defined   : field saturates to the most positive/negative value on overflow
//   undefined : field is the truncated low FIELD_WIDTH bits of the scaled offset
//
// Ports:
//   clk        in   clock, rising edge
//   rst_n      in   synchronous active-low reset
//   in_valid   in   request valid
//   in_ready   out  request accepted when high (IDLE only)
//   pc         in   base address
//   target     in   destination address
//   jump       in   1 = scale by SHIFT, 0 = no scaling
//   out_valid  out  result valid (DONE)
//   out_ready  in   consumer accepts result
//   field      out  encoded offset
//   overflow   out  scaled offset does not fit FIELD_WIDTH signed bits
//   misalign   out  jump and a nonzero bit was shifted out

module offset_field_encoder #(
    parameter int FIELD_WIDTH = 12,
    parameter int WORD_WIDTH  = 16,
    parameter int SHIFT       = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WORD_WIDTH-1:0]  pc,
    input  logic [WORD_WIDTH-1:0]  target,
    input  logic                   jump,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [FIELD_WIDTH-1:0] field,
    output logic                   overflow,
    output logic                   misalign
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SUB,
        S_ALIGN,
        S_RANGE,
        S_DONE
    } state_t;

    // Bits discarded by the jump shift; all-zero when SHIFT is 0.
    localparam logic [WORD_WIDTH-1:0] LOW_MASK = (WORD_WIDTH'(1) << SHIFT) - WORD_WIDTH'(1);

    localparam logic [FIELD_WIDTH-1:0] FIELD_MAX = {1'b0, {(FIELD_WIDTH-1){1'b1}}};
    localparam logic [FIELD_WIDTH-1:0] FIELD_MIN = {1'b1, {(FIELD_WIDTH-1){1'b0}}};

    state_t state;
    state_t state_next;

    logic [WORD_WIDTH-1:0] pc_q;
    logic [WORD_WIDTH-1:0] target_q;
    logic                  jump_q;
    logic [WORD_WIDTH-1:0] diff_q;
    logic [WORD_WIDTH-1:0] scaled_q;
    logic                  misalign_q;

    logic [WORD_WIDTH-FIELD_WIDTH:0] top_bits;
    logic                            range_ovf;
    logic [FIELD_WIDTH-1:0]          field_next;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = S_SUB;
                end
            end
            S_SUB:   state_next = S_ALIGN;
            S_ALIGN: state_next = S_RANGE;
            S_RANGE: state_next = S_DONE;
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The scaled value fits the field only if every bit from the field's sign
    // bit upward is a copy of that sign bit.
    always_comb begin
        top_bits  = scaled_q[WORD_WIDTH-1:FIELD_WIDTH-1];
        range_ovf = !((&top_bits) || !(|top_bits));
`ifdef OFFSET_FIELD_ENCODER_SATURATE_EN
        if (range_ovf) begin
            field_next = scaled_q[WORD_WIDTH-1] ? FIELD_MIN : FIELD_MAX;
        end else begin
            field_next = scaled_q[FIELD_WIDTH-1:0];
        end
`else
        field_next = scaled_q[FIELD_WIDTH-1:0];
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= '0;
            target_q   <= '0;
            jump_q     <= 1'b0;
            diff_q     <= '0;
            scaled_q   <= '0;
            misalign_q <= 1'b0;
            field      <= '0;
            overflow   <= 1'b0;
            misalign   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid) begin
                        pc_q     <= pc;
                        target_q <= target;
                        jump_q   <= jump;
                    end
                end
                S_SUB: begin
                    diff_q <= target_q - pc_q;
                end
                S_ALIGN: begin
                    if (jump_q) begin
                        scaled_q   <= $signed(diff_q) >>> SHIFT;
                        misalign_q <= |(diff_q & LOW_MASK);
                    end else begin
                        scaled_q   <= diff_q;
                        misalign_q <= 1'b0;
                    end
                end
                // Visible outputs only move on the edge into DONE and then
                // hold until the next result.
                S_RANGE: begin
                    field    <= field_next;
                    overflow <= range_ovf;
                    misalign <= misalign_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_offset_field_encoder.sv
// tb/tb_offset_field_encoder.sv - self-checking bench for offset_field_encoder

module tb_offset_field_encoder;

    localparam int FW = 12;
    localparam int WW = 16;
    localparam int SH = 1;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] pc;
    logic [WW-1:0] target;
    logic          jump;
    logic          out_valid;
    logic          out_ready;
    logic [FW-1:0] field;
    logic          overflow;
    logic          misalign;

    int total = 0;
    int bad   = 0;

    offset_field_encoder #(.FIELD_WIDTH(FW), .WORD_WIDTH(WW), .SHIFT(SH)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .pc(pc), .target(target), .jump(jump), .out_valid(out_valid),
        .out_ready(out_ready), .field(field), .overflow(overflow), .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arithmetic statement of the encoding rules on plain integers.
    function automatic void model(input logic [WW-1:0] p, input logic [WW-1:0] t, input logic j,
                                  output logic [FW-1:0] f, output logic o, output logic m);
        int du;
        int ds;
        int sc;
        int dv;
        du = int'(t) - int'(p);
        if (du < 0) du += (1 << WW);
        ds = (du >= (1 << (WW-1))) ? du - (1 << WW) : du;
        if (j && SH > 0) begin
            dv = 1 << SH;
            m  = (du % dv) != 0;
            sc = (ds - (du % dv)) / dv;
        end else begin
            m  = 1'b0;
            sc = ds;
        end
        o = (sc < -(1 << (FW-1))) || (sc > (1 << (FW-1)) - 1);
`ifdef OFFSET_FIELD_ENCODER_SATURATE_EN
        if (o) f = (sc < 0) ? FW'(1 << (FW-1)) : FW'((1 << (FW-1)) - 1);
        else   f = FW'(sc);
`else
        f = FW'(sc);
`endif
    endfunction

    // Cycle model: one request in flight, result visible four negedges after
    // the negedge where the accept was seen, outputs held between results.
    initial begin : compare
        logic          busy;
        int            age;
        logic [WW-1:0] ip;
        logic [WW-1:0] it;
        logic          ij;
        logic [FW-1:0] hf;
        logic          ho;
        logic          hm;
        busy = 1'b0; age = 0; hf = '0; ho = 1'b0; hm = 1'b0;
        ip = '0; it = '0; ij = 1'b0;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (busy) age++;
            if (busy && age == 4) model(ip, it, ij, hf, ho, hm);
            check("cyc_in_ready", in_ready, !busy);
            check("cyc_out_valid", out_valid, busy && age >= 4);
            check("cyc_field", field, hf);
            check("cyc_overflow", overflow, ho);
            check("cyc_misalign", misalign, hm);
            if (!rst_n) begin
                busy = 1'b0; age = 0; hf = '0; ho = 1'b0; hm = 1'b0;
            end else if (!busy && in_valid) begin
                busy = 1'b1; age = 0; ip = pc; it = target; ij = jump;
            end else if (busy && age >= 4 && out_ready) begin
                busy = 1'b0;
            end
        end
    end

    task automatic wait_ready();
        int g = 0;
        while (!in_ready && g < 20) begin
            @(posedge clk); #1; g++;
        end
        check("ready_timeout", g < 20, 1'b1);
    endtask

    task automatic wait_out(output int lat);
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        check("out_timeout", out_valid, 1'b1);
    endtask

    task automatic do_req(input logic [WW-1:0] p, input logic [WW-1:0] t, input logic j,
                          output logic [FW-1:0] f, output logic o, output logic m, output int lat);
        @(posedge clk); #1;
        in_valid = 1'b1; pc = p; target = t; jump = j;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        f = field; o = overflow; m = misalign;
    endtask

    localparam int NV = 11;
    logic [WW-1:0] v_pc   [NV] = '{16'h0100, 16'h0010, 16'h0000, 16'h0000, 16'h0000, 16'hFFFE,
                                   16'h0200, 16'h1000, 16'h0000, 16'h0800, 16'h0000};
    logic [WW-1:0] v_tgt  [NV] = '{16'h0104, 16'h0000, 16'h0800, 16'h0800, 16'h0003, 16'h0002,
                                   16'h0100, 16'h0000, 16'h07FF, 16'h0000, 16'h1001};
    logic          v_j    [NV] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic [FW-1:0] v_fw   [NV] = '{12'h002, 12'hFF0, 12'h800, 12'h400, 12'h001, 12'h004,
                                   12'hF80, 12'h000, 12'h7FF, 12'h800, 12'h800};
    logic [FW-1:0] v_fs   [NV] = '{12'h002, 12'hFF0, 12'h7FF, 12'h400, 12'h001, 12'h004,
                                   12'hF80, 12'h800, 12'h7FF, 12'h800, 12'h7FF};
    logic          v_o    [NV] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic          v_m    [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin : stim
        logic [FW-1:0] f;
        logic          o;
        logic          m;
        logic [WW-1:0] rt;
        int            lat;
        int            seen;
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        pc = '0; target = '0; jump = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_field", field, 12'h000);
        check("rst_overflow", overflow, 1'b0);
        check("rst_misalign", misalign, 1'b0);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            do_req(v_pc[i], v_tgt[i], v_j[i], f, o, m, lat);
`ifdef OFFSET_FIELD_ENCODER_SATURATE_EN
            check($sformatf("vec%0d_field", i), f, v_fs[i]);
`else
            check($sformatf("vec%0d_field", i), f, v_fw[i]);
`endif
            check($sformatf("vec%0d_overflow", i), o, v_o[i]);
            check($sformatf("vec%0d_misalign", i), m, v_m[i]);
            check($sformatf("vec%0d_latency", i), lat, 4);
            if (i == 1) begin
                rt = {{(WW-FW){f[FW-1]}}, f};
                check("roundtrip_neg", rt, 16'hFFF0);
            end
            if (i == 6) begin
                rt = {{(WW-FW){f[FW-1]}}, f} << SH;
                check("roundtrip_jump", rt, 16'hFF00);
            end
        end

        // Stall in DONE while a competing request is offered.
        @(posedge clk); #1;
        out_ready = 1'b0;
        in_valid = 1'b1; pc = 16'h0000; target = 16'h0010; jump = 1'b0;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        in_valid = 1'b1; pc = 16'h0000; target = 16'h0020; jump = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            check("stall_out_valid", out_valid, 1'b1);
            check("stall_in_ready", in_ready, 1'b0);
            check("stall_field", field, 12'h010);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("release_idle", in_ready, 1'b1);
        check("release_out_valid", out_valid, 1'b0);
        @(posedge clk); #1;
        check("release_accept", in_ready, 1'b0);
        in_valid = 1'b0;
        wait_out(lat);
        check("after_stall_field", field, 12'h020);

        // Reset while the request sits in ALIGN.
        @(posedge clk); #1;
        in_valid = 1'b1; pc = 16'h0000; target = 16'h0040; jump = 1'b0;
        wait_ready();
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_field", field, 12'h000);
        check("midrst_overflow", overflow, 1'b0);
        check("midrst_misalign", misalign, 1'b0);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("midrst_no_result", seen, 0);

        do_req(16'h0100, 16'h00FA, 1'b1, f, o, m, lat);
        check("recover_field", f, 12'hFFD);
        check("recover_misalign", m, 1'b0);
        @(posedge clk); #1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("test done: total=%0d bad=%0d", total, bad + 1);
        $finish;
    end

endmodule
